gf_divider_scheduler: RTL



---
 rtl/gf_divider_scheduler.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/gf_divider_scheduler.sv
// Round-robin scheduler sharing one Fermat-inversion GF(2^M) divider among N_REQ
// requesters. Quotients are returned in the trace-dual basis: bit i = Tr(alpha^i * q).

module finite_divider #(
    parameter int M = 6
) (
    input  logic         clk,
    input  logic         start,
    input  logic [M-1:0] standard_numer,
    input  logic [M-1:0] standard_denom,
    output logic         busy,
    output logic [M-1:0] dual_out
);
    // Tap k of a primitive trinomial x^M + x^k + 1; 0 means no trinomial is available.
    function automatic int trinomial_tap(input int m);
        case (m)
            2, 3, 4, 6, 7, 15: return 1;
            5, 11:             return 2;
            10:                return 3;
            9:                 return 4;
            default:           return 0;
        endcase
    endfunction

    localparam int TAP   = trinomial_tap(M);
    localparam int CNT_W = $clog2(M);
    localparam logic [M-1:0] POLY = M'((1 << TAP) | 1);

    if (TAP == 0) begin : g_no_trinomial
        $error("finite_divider: GF(2^%0d) has no supported trinomial", M);
    end

    function automatic logic [M-1:0] gf_mul(input logic [M-1:0] a, input logic [M-1:0] b);
        logic [M-1:0] r;
        logic [M-1:0] s;
        r = '0;
        s = a;
        for (int i = 0; i < M; i++) begin
            if (b[i]) r = r ^ s;
            s = {s[M-2:0], 1'b0} ^ (s[M-1] ? POLY : '0);
        end
        return r;
    endfunction

    // tr[n] = Tr(alpha^n) for n = 0 .. 2M-2, the constants of the dual-basis map.
    function automatic logic [2*M-2:0] trace_vec();
        logic [2*M-2:0] v;
        logic [M-1:0]   e;
        logic [M-1:0]   t;
        logic [M-1:0]   s;
        v = '0;
        e = M'(1);
        for (int n = 0; n < 2*M-1; n++) begin
            t = e;
            s = e;
            for (int j = 1; j < M; j++) begin
                t = gf_mul(t, t);
                s = s ^ t;
            end
            v[n] = s[0];
            e = gf_mul(e, M'(2));
        end
        return v;
    endfunction

    localparam logic [2*M-2:0] TR = trace_vec();

    logic [M-1:0]     sq_reg;
    logic [M-1:0]     acc_reg;
    logic [CNT_W-1:0] cnt_reg;
    logic             busy_reg;
    logic [M-1:0]     product;

    // a^-1 = a^(2^M-2) = product of a^(2^k) for k = 1 .. M-1, one factor per cycle.
    always_ff @(posedge clk) begin
        if (start) begin
            sq_reg   <= gf_mul(standard_denom, standard_denom);
            acc_reg  <= M'(1);
            cnt_reg  <= CNT_W'(M - 1);
            busy_reg <= 1'b1;
        end else if (busy_reg) begin
            acc_reg  <= gf_mul(acc_reg, sq_reg);
            sq_reg   <= gf_mul(sq_reg, sq_reg);
            cnt_reg  <= cnt_reg - 1'b1;
            busy_reg <= (cnt_reg != CNT_W'(1));
        end
    end

    assign busy    = busy_reg;
    assign product = gf_mul(acc_reg, standard_numer);

    for (genvar gi = 0; gi < M; gi++) begin : g_dual
        assign dual_out[gi] = ^(product & TR[gi +: M]);
    end
endmodule

module gf_divider_scheduler #(
    parameter int M     = 6,
    parameter int N_REQ = 4,
    localparam int ID_W = ($clog2(N_REQ) > 1) ? $clog2(N_REQ) : 1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_REQ-1:0]   req_valid,
    output logic [N_REQ-1:0]   req_ready,
    input  logic [M*N_REQ-1:0] req_numer,
    input  logic [M*N_REQ-1:0] req_denom,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [ID_W-1:0]    out_id,
    output logic [M-1:0]       out_quot,
    output logic               out_div_zero
);
    typedef enum logic [1:0] {IDLE, LOAD, RUN, RESP} state_t;

    state_t          state_reg;
    state_t          state_next;
    logic [ID_W-1:0] ptr_reg;
    logic [ID_W-1:0] winner;
    logic [ID_W-1:0] cand;
    logic            found;
    logic [M-1:0]    numer_reg;
    logic [M-1:0]    denom_reg;
    logic [ID_W-1:0] id_reg;
    logic            start;
    logic            busy;
    logic [M-1:0]    dual_out;

    finite_divider #(.M(M)) u_div (
        .clk            (clk),
        .start          (start),
        .standard_numer (numer_reg),
        .standard_denom (denom_reg),
        .busy           (busy),
        .dual_out       (dual_out)
    );

    // First pending requester searching upward from the one after the last winner.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        cand   = '0;
        for (int off = 1; off <= N_REQ; off++) begin
            cand = ID_W'((int'(ptr_reg) + off) % N_REQ);
            if (!found && req_valid[cand]) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    always_comb begin
        state_next = state_reg;
        req_ready  = '0;
        start      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (found) begin
                    req_ready  = N_REQ'(1) << winner;
                    state_next = LOAD;
                end
            end
            LOAD: begin
                start      = 1'b1;
                state_next = RUN;
            end
            RUN:  if (!busy) state_next = RESP;
            RESP: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (state_reg == IDLE && found) begin
            numer_reg <= req_numer[winner*M +: M];
            denom_reg <= req_denom[winner*M +: M];
            id_reg    <= winner;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg    <= IDLE;
            ptr_reg      <= ID_W'(N_REQ - 1);
            out_valid    <= 1'b0;
            out_id       <= '0;
            out_quot     <= '0;
            out_div_zero <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (state_reg == IDLE && found) ptr_reg <= winner;
            if (state_reg == RUN && !busy) begin
                out_quot     <= (denom_reg == '0) ? '0 : dual_out;
                out_div_zero <= (denom_reg == '0);
                out_id       <= id_reg;
                out_valid    <= 1'b1;
            end
            if (state_reg == RESP && out_ready) out_valid <= 1'b0;
        end
    end
endmodule
